pingpong_ctrl: RTL

PINGPONG_CTRL -- requirements
Module: pingpong_ctrl

---
 rtl/pingpong_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pingpong_ctrl.sv
// pingpong_ctrl: ping-pong RAM bank controller. Sampler fills one bank while the
// read FSM streams the other bank to the consumer; banks swap when the write bank
// is full and the reader is done. Overflowing samples are dropped and flagged.
// Ports: clk, btn_s1_resetb (async active-low), sample_valid_i, clear_i,
//   rd_ready_i; wr_en_o/wr_bank_o/wr_addr_o, rd_bank_o/rd_addr_o/rd_valid_o,
//   buffer_ready_o (swap pulse), buffer_full_o (sticky overflow),
//   swap_cnt_o/drop_cnt_o (statistics).
// Optional macro PINGPONG_CTRL_STATS_EN enables the saturating statistics
// counters; without it both counter ports are tied to zero.
module pingpong_ctrl #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          btn_s1_resetb,
    input  logic          sample_valid_i,
    input  logic          clear_i,
    output logic          wr_en_o,
    output logic          wr_bank_o,
    output logic [AW-1:0] wr_addr_o,
    output logic          rd_bank_o,
    output logic [AW-1:0] rd_addr_o,
    output logic          rd_valid_o,
    input  logic          rd_ready_i,
    output logic          buffer_ready_o,
    output logic          buffer_full_o,
    output logic [15:0]   swap_cnt_o,
    output logic [15:0]   drop_cnt_o
);

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_ADDR  = 2'd1,
        R_VALID = 2'd2
    } rd_state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    // Single release stage: the logic first acts on the second edge after
    // the button reset is released, while assertion stays asynchronous.
    logic rst_n_q;
    always_ff @(posedge clk or negedge btn_s1_resetb) begin
        if (!btn_s1_resetb) rst_n_q <= 1'b0;
        else                rst_n_q <= 1'b1;
    end

    rd_state_t     state_q, state_d;
    logic          wr_bank_q, wr_bank_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          pend_q, pend_d;
    logic          full_q, full_d;
    logic          brdy_q, brdy_d;

    logic wr_en;
    logic bank_full;
    logic rd_idle;
    logic xfer;
    logic rd_last;
    logic swap;

    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        pend_d    = pend_q;
        full_d    = full_q;

        rd_idle   = (state_q == R_IDLE);
        xfer      = (state_q == R_VALID) && rd_ready_i;
        rd_last   = xfer && (rd_addr_q == LAST);
        // Writes are blocked while a swap is pending (overflow drop).
        wr_en     = rst_n_q && sample_valid_i && !pend_q;
        bank_full = wr_en && (wr_addr_q == LAST);
        // A full bank swaps immediately if the reader is free (or frees up
        // this cycle); otherwise the swap waits one cycle in R_IDLE.
        swap      = (pend_q && rd_idle)
                 || (bank_full && (rd_idle || rd_last));
        brdy_d    = swap;

        if (wr_en) wr_addr_d = wr_addr_q + 1'b1;

        unique case (state_q)
            R_IDLE:  state_d = R_IDLE;
            R_ADDR:  state_d = R_VALID;
            R_VALID: begin
                if (xfer) begin
                    if (rd_last) begin
                        state_d = R_IDLE;
                    end else begin
                        state_d   = R_ADDR;
                        rd_addr_d = rd_addr_q + 1'b1;
                    end
                end
            end
            default: state_d = R_IDLE;
        endcase

        // Set beats clear on the same cycle.
        if (bank_full && !(rd_idle || rd_last)) begin
            pend_d = 1'b1;
            full_d = 1'b1;
        end else if (clear_i) begin
            full_d = 1'b0;
        end

        if (swap) begin
            wr_bank_d = ~wr_bank_q;
            state_d   = R_ADDR;
            rd_addr_d = '0;
            pend_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            state_q   <= R_IDLE;
            wr_bank_q <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            pend_q    <= 1'b0;
            full_q    <= 1'b0;
            brdy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_bank_q <= wr_bank_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            pend_q    <= pend_d;
            full_q    <= full_d;
            brdy_q    <= brdy_d;
        end
    end

    assign wr_en_o        = wr_en;
    assign wr_bank_o      = wr_bank_q;
    assign wr_addr_o      = wr_addr_q;
    assign rd_bank_o      = ~wr_bank_q;
    assign rd_addr_o      = rd_addr_q;
    assign rd_valid_o     = (state_q == R_VALID);
    assign buffer_ready_o = brdy_q;
    assign buffer_full_o  = full_q;

`ifdef PINGPONG_CTRL_STATS_EN
    logic        drop;
    logic [15:0] swap_cnt_q, swap_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign drop = rst_n_q && sample_valid_i && pend_q;

    always_comb begin
        swap_cnt_d = swap_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (swap && (swap_cnt_q != 16'hFFFF)) swap_cnt_d = swap_cnt_q + 16'd1;
        if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            swap_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            swap_cnt_q <= swap_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign swap_cnt_o = swap_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
`else
    assign swap_cnt_o = '0;
    assign drop_cnt_o = '0;
`endif

endmodule
